mips_bus_master: RTL

Parametrised, buffered Avalon-MM master that sits between the CPU memory unit and the external Avalon bus, replacing direct single-request bus driving. It queues load/store requests in an in-order FIFO, drives one Avalon transfer at a time under `waitrequest` back-pressure, returns read data on a response channel, and optionally byte-reverses data lanes for endianness conversion.

---
 rtl/mips_bus_pkg.sv | 28 ++
 rtl/bus_req_fifo.sv | 57 +++++
 rtl/mips_bus_master.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types and helpers for the buffered Avalon-MM bus master.
package mips_bus_pkg;

   localparam int BUS_DATA_W = 32;
   localparam int BUS_ADDR_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,   // queue empty
      ISSUE = 2'd1,   // head is on the bus
      SKIP  = 2'd2    // head has no enabled lanes, retire without a strobe
   } bus_state_t;

   // Reference request layout at the default bus widths. Instances with other
   // widths declare a struct with the same field order.
   typedef struct packed {
      logic                    write;
      logic [BUS_ADDR_W-1:0]   addr;
      logic [BUS_DATA_W-1:0]   wdata;
      logic [BUS_DATA_W/8-1:0] byteenable;
   } bus_req_t;

   // Source lane for output lane 'lane' when lanes are optionally reversed.
   // Evaluated at elaboration, so it costs nothing but wiring.
   function automatic int lane_map(input int lane, input int nlanes, input bit swap);
      return swap ? (nlanes - 1 - lane) : lane;
   endfunction

endpackage

// File: rtl/bus_req_fifo.sv
// In-order request queue. Exposes the head and the entry behind it so the
// owner can see what the head will be after a pop without extra latency.
module bus_req_fifo
   import mips_bus_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type ENTRY_T = bus_req_t
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_push,
   input  ENTRY_T                     i_din,
   input  logic                       i_pop,
   output ENTRY_T                     o_head,
   output ENTRY_T                     o_head2,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   ENTRY_T        r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] w_rd_ptr1;
   logic [CW-1:0] r_count;

   // DEPTH is a power of two, so pointers wrap naturally
   assign w_rd_ptr1 = r_rd_ptr + 1'b1;

   // Pointer and occupancy bookkeeping; full/empty come from the counter only
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_pop)  r_rd_ptr <= w_rd_ptr1;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: ;
         endcase
      end
   end

   // Entry storage; stale contents are harmless because the count gates use
   always_ff @(posedge i_clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_din;
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_head2 = r_mem[w_rd_ptr1];
   assign o_count = r_count;

endmodule

// File: rtl/mips_bus_master.sv
// Buffered Avalon-MM master: queues CPU loads/stores, runs them one at a time
// under waitrequest, returns load data in order, optional lane reversal.
module mips_bus_master
   import mips_bus_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int SWAP_BYTES = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_write,
   input  logic [ADDR_WIDTH-1:0]      req_addr,
   input  logic [DATA_WIDTH-1:0]      req_wdata,
   input  logic [DATA_WIDTH/8-1:0]    req_byteenable,
   output logic                       rsp_valid,
   output logic [DATA_WIDTH-1:0]      rsp_rdata,
   output logic [$clog2(DEPTH+1)-1:0] occupancy,
   output logic                       busy,
   output logic [ADDR_WIDTH-1:0]      address,
   output logic                       read,
   output logic                       write,
   input  logic                       waitrequest,
   output logic [DATA_WIDTH-1:0]      writedata,
   output logic [DATA_WIDTH/8-1:0]    byteenable,
   input  logic [DATA_WIDTH-1:0]      readdata
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int CW = $clog2(DEPTH+1);

   // Same field order as bus_req_t, sized for this instance
   typedef struct packed {
      logic                  write;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
      logic [NB-1:0]         byteenable;
   } req_t;

   bus_state_t            r_state;
   bus_state_t            w_state_nxt;
   req_t                  w_req_in;
   req_t                  w_head;
   req_t                  w_head2;
   req_t                  w_head_nxt;
   logic [CW-1:0]         w_count;
   logic [CW-1:0]         w_cnt_nxt;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_done;
   logic [DATA_WIDTH-1:0] w_wd_sw;
   logic [NB-1:0]         w_be_sw;
   logic [DATA_WIDTH-1:0] w_rd_sw;
   logic                  r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;

   assign w_req_in  = {req_write, req_addr, req_wdata, req_byteenable};
   assign req_ready = (w_count < CW'(DEPTH));
   assign w_push    = req_valid && req_ready;
   assign w_done    = (r_state == ISSUE) && !waitrequest;
   assign w_pop     = w_done || (r_state == SKIP);

   bus_req_fifo #(
      .DEPTH   (DEPTH),
      .ENTRY_T (req_t)
   ) u_fifo (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_push  (w_push),
      .i_din   (w_req_in),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_head2 (w_head2),
      .o_count (w_count)
   );

   // Lane steering between CPU order and bus order
   for (genvar g = 0; g < NB; g++) begin : g_lane
      localparam int S = lane_map(g, NB, SWAP_BYTES != 0);
      assign w_wd_sw[g*8 +: 8] = w_head.wdata[S*8 +: 8];
      assign w_be_sw[g]        = w_head.byteenable[S];
      assign w_rd_sw[g*8 +: 8] = readdata[S*8 +: 8];
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state is decided from the head as it will look after this edge,
   // so a freshly pushed entry reaches the bus one cycle later
   always_comb begin
      w_cnt_nxt = w_count;
      if (w_push && !w_pop)      w_cnt_nxt = w_count + 1'b1;
      else if (!w_push && w_pop) w_cnt_nxt = w_count - 1'b1;

      w_head_nxt = w_head;
      if (w_pop)               w_head_nxt = (w_count > CW'(1)) ? w_head2 : w_req_in;
      else if (w_count == '0)  w_head_nxt = w_req_in;

      w_state_nxt = IDLE;
      if (w_cnt_nxt != '0)
         w_state_nxt = (w_head_nxt.byteenable == '0) ? SKIP : ISSUE;
   end

   // Avalon outputs: driven from the head only while it is on the bus
   always_comb begin
      read       = 1'b0;
      write      = 1'b0;
      address    = '0;
      writedata  = '0;
      byteenable = '0;
      if (r_state == ISSUE) begin
         read       = !w_head.write;
         write      = w_head.write;
         address    = w_head.addr & ~ADDR_WIDTH'(NB - 1);
         writedata  = w_wd_sw;
         byteenable = w_be_sw;
      end
   end

   // Load responses: bus data on completion, zero for a skipped load
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         if (w_done && !w_head.write) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_rd_sw;
         end else if ((r_state == SKIP) && !w_head.write) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
         end
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign occupancy = w_count;
   assign busy      = (w_count != '0);

endmodule
